// File: rtl/memory_bus_pkg.sv
// memory_bus_pkg: shared definitions for the banked memory bus.
//   - bus_state_t : FSM state encoding (IDLE=0, WAIT=1, ACK=2)
//   - WAIT_FIELD_W: width of one per-bank wait-state field
//   - BANK_*      : default bank map (RAM, ROM, peripherals, block RAM)
package memory_bus_pkg;

  localparam int WAIT_FIELD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } bus_state_t;

  localparam int BANK_RAM       = 0;
  localparam int BANK_ROM       = 1;
  localparam int BANK_PERIPH    = 2;
  localparam int BANK_BLOCK_RAM = 3;

endpackage

// File: rtl/banked_memory_bus_bank_decode.sv
// bank_decode: combinational address decode for the banked memory bus.
// Ports:
//   address       in   CPU address
//   sel           out  bank index taken from the bank field of the address
//   sel_onehot    out  one-hot form of sel
//   wait_states   out  programmed wait-state count of the selected bank
//   write_protect out  1 when writes to the selected bank are dropped
module bank_decode
  import memory_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int BANK_BITS  = 2,
  parameter int BANK_LSB   = 13,
  localparam int NUM_BANKS = 2**BANK_BITS,
  parameter logic [WAIT_FIELD_W*NUM_BANKS-1:0] WAIT_STATES   = '0,
  parameter logic [NUM_BANKS-1:0]              WRITE_PROTECT = '0
) (
  input  logic [ADDR_WIDTH-1:0]   address,
  output logic [BANK_BITS-1:0]    sel,
  output logic [NUM_BANKS-1:0]    sel_onehot,
  output logic [WAIT_FIELD_W-1:0] wait_states,
  output logic                    write_protect
);

  assign sel = address[BANK_LSB +: BANK_BITS];

  always_comb begin
    sel_onehot      = '0;
    sel_onehot[sel] = 1'b1;
  end

  assign wait_states   = WAIT_STATES[int'(sel)*WAIT_FIELD_W +: WAIT_FIELD_W];
  assign write_protect = WRITE_PROTECT[sel];

endmodule

// File: rtl/banked_memory_bus.sv
// banked_memory_bus: registered CPU bus that decodes an access into one of
// NUM_BANKS banks and holds the CPU until the bank completes. Each bank has
// a programmable wait-state count and a bank_ready handshake.
// Optional feature macro: BUS_TIMEOUT_EN (bank_ready timeout with bus_error).
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   address, data_in     CPU address / write data
//   bus_enable           CPU access request
//   write_enable         1 = write, 0 = read
//   data_out             registered read data
//   ready                one-cycle completion strobe
//   bus_error            timeout flag, valid with ready
//   bank_address         latched address to all banks
//   bank_data_out        latched write data to all banks
//   bank_enable          one-hot active-bank select (WAIT state)
//   bank_write_enable    one-hot, one-cycle write strobe
//   bank_data_in         packed per-bank read data
//   bank_ready           per-bank ready handshake
//
// state | meaning
// IDLE  | waiting for bus_enable; request is latched on acceptance
// WAIT  | bank selected; wait states counting down, then bank_ready awaited
// ACK   | ready strobe; always returns to IDLE
module banked_memory_bus
  import memory_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int BANK_BITS  = 2,
  parameter int BANK_LSB   = 13,
  localparam int NUM_BANKS = 2**BANK_BITS,
  parameter logic [WAIT_FIELD_W*NUM_BANKS-1:0] WAIT_STATES   = '0,
  parameter logic [NUM_BANKS-1:0]              WRITE_PROTECT = NUM_BANKS'(1 << BANK_ROM),
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [ADDR_WIDTH-1:0]           address,
  input  logic [DATA_WIDTH-1:0]           data_in,
  input  logic                            bus_enable,
  input  logic                            write_enable,
  output logic [DATA_WIDTH-1:0]           data_out,
  output logic                            ready,
  output logic                            bus_error,
  output logic [ADDR_WIDTH-1:0]           bank_address,
  output logic [DATA_WIDTH-1:0]           bank_data_out,
  output logic [NUM_BANKS-1:0]            bank_enable,
  output logic [NUM_BANKS-1:0]            bank_write_enable,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] bank_data_in,
  input  logic [NUM_BANKS-1:0]            bank_ready
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  bus_state_t state, state_nx;

  logic [BANK_BITS-1:0]    dec_sel, sel_q;
  logic [NUM_BANKS-1:0]    dec_onehot, onehot_q;
  logic [WAIT_FIELD_W-1:0] dec_wait, wait_cnt;
  logic                    dec_wp, wp_q, we_q, first_q;
  logic                    done;

  bank_decode #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .BANK_BITS     (BANK_BITS),
    .BANK_LSB      (BANK_LSB),
    .WAIT_STATES   (WAIT_STATES),
    .WRITE_PROTECT (WRITE_PROTECT)
  ) u_decode (
    .address       (address),
    .sel           (dec_sel),
    .sel_onehot    (dec_onehot),
    .wait_states   (dec_wait),
    .write_protect (dec_wp)
  );

`ifdef BUS_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] to_cnt;
  logic            timeout, err_q;
`endif

  always_comb begin
    state_nx = state;
    done     = 1'b0;
`ifdef BUS_TIMEOUT_EN
    timeout  = 1'b0;
`endif
    case (state)
      ST_IDLE: if (bus_enable) state_nx = ST_WAIT;
      ST_WAIT: begin
        if (wait_cnt == '0) begin
          if (bank_ready[sel_q]) begin
            done     = 1'b1;
            state_nx = ST_ACK;
          end
`ifdef BUS_TIMEOUT_EN
          else if (to_cnt == '0) begin
            timeout  = 1'b1;
            state_nx = ST_ACK;
          end
`endif
        end
      end
      ST_ACK:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  assign ready             = (state == ST_ACK);
  assign bank_enable       = (state == ST_WAIT) ? onehot_q : '0;
  // write strobe only on the first WAIT cycle; protected banks never see it
  assign bank_write_enable = (state == ST_WAIT && first_q && we_q && !wp_q) ? onehot_q : '0;
`ifdef BUS_TIMEOUT_EN
  assign bus_error         = ready & err_q;
`else
  assign bus_error         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      data_out      <= '0;
      bank_address  <= '0;
      bank_data_out <= '0;
      sel_q         <= '0;
      onehot_q      <= '0;
      wp_q          <= 1'b0;
      we_q          <= 1'b0;
      first_q       <= 1'b0;
      wait_cnt      <= '0;
`ifdef BUS_TIMEOUT_EN
      to_cnt        <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: begin
          if (bus_enable) begin
            bank_address  <= address;
            bank_data_out <= data_in;
            we_q          <= write_enable;
            sel_q         <= dec_sel;
            onehot_q      <= dec_onehot;
            wp_q          <= dec_wp;
            wait_cnt      <= dec_wait;
            first_q       <= 1'b1;
`ifdef BUS_TIMEOUT_EN
            to_cnt        <= TO_W'(TIMEOUT_CYCLES - 1);
            err_q         <= 1'b0;
`endif
          end
        end
        ST_WAIT: begin
          first_q <= 1'b0;
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
          end else if (done) begin
            if (!we_q) data_out <= bank_data_in[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH];
          end
`ifdef BUS_TIMEOUT_EN
          else if (timeout) begin
            err_q <= 1'b1;
            if (!we_q) data_out <= '1;
          end else begin
            to_cnt <= to_cnt - 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_banked_memory_bus.sv
module tb_banked_memory_bus;
  import memory_bus_pkg::*;

  localparam int TO_CYC = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] address, data_in;
  logic        bus_enable, write_enable;
  logic [15:0] data_out;
  logic        ready, bus_error;
  logic [15:0] bank_address, bank_data_out;
  logic [3:0]  bank_enable, bank_write_enable;
  logic [63:0] bank_data_in;
  logic [3:0]  bank_ready;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_dout;
  int wait_of [4];

  always #5 clk = ~clk;

  banked_memory_bus #(
    .ADDR_WIDTH     (16),
    .DATA_WIDTH     (16),
    .BANK_BITS      (2),
    .BANK_LSB       (13),
    .WAIT_STATES    (16'h3050),
    .WRITE_PROTECT  (4'b0010),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .address           (address),
    .data_in           (data_in),
    .bus_enable        (bus_enable),
    .write_enable      (write_enable),
    .data_out          (data_out),
    .ready             (ready),
    .bus_error         (bus_error),
    .bank_address      (bank_address),
    .bank_data_out     (bank_data_out),
    .bank_enable       (bank_enable),
    .bank_write_enable (bank_write_enable),
    .bank_data_in      (bank_data_in),
    .bank_ready        (bank_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ":ready"}, ready, 0);
    chk({tag, ":bus_error"}, bus_error, 0);
    chk({tag, ":bank_en"}, bank_enable, 0);
    chk({tag, ":bank_we"}, bank_write_enable, 0);
    chk({tag, ":data_out"}, data_out, 0);
    chk({tag, ":bank_addr"}, bank_address, 0);
    chk({tag, ":bank_dout"}, bank_data_out, 0);
  endtask

  // One CPU access. The selected bank holds bank_ready low for cycles
  // 1..n_low after the request edge; the expected latency follows from
  // whichever ends later: the wait-state count or the bank_ready stall.
  task automatic do_access(input string tag, input logic [15:0] addr, input logic [15:0] wdata,
                           input logic we, input int n_low, input logic [15:0] rdata);
    int bank, w, exp_lat, cyc, en_cycles, wstb, wstb_cyc;
    logic done, bad_sel, prot;
    logic [15:0] stb_addr, stb_data;
    logic [3:0] onehot;
    bank = int'(addr[14:13]);
    w = wait_of[bank];
    prot = (bank == BANK_ROM);
    onehot = 4'b0001 << bank;
    exp_lat = ((w > n_low) ? w : n_low) + 2;
    cyc = 0; en_cycles = 0; wstb = 0; wstb_cyc = 0; done = 1'b0; bad_sel = 1'b0;
    stb_addr = '0; stb_data = '0;
    @(negedge clk);
    address = addr; data_in = wdata; write_enable = we; bus_enable = 1'b1;
    bank_data_in = {$urandom, $urandom};
    bank_data_in[bank*16 +: 16] = rdata;
    bank_ready = 4'hF;
    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      bank_ready[bank] = (cyc > n_low);
      if (bank_enable != 0) begin
        en_cycles++;
        if (bank_enable != onehot) bad_sel = 1'b1;
      end
      if (bank_write_enable != 0) begin
        wstb++; wstb_cyc = cyc; stb_addr = bank_address; stb_data = bank_data_out;
        if (bank_write_enable != onehot) bad_sel = 1'b1;
      end
      if (ready) begin
        done = 1'b1;
        bus_enable = 1'b0;
      end
    end
    chk({tag, ":done"}, done, 1);
    chk({tag, ":latency"}, cyc, exp_lat);
    chk({tag, ":en_cycles"}, en_cycles, exp_lat - 1);
    chk({tag, ":bad_sel"}, bad_sel, 0);
    chk({tag, ":wstrobes"}, wstb, (we && !prot) ? 1 : 0);
    if (wstb != 0) begin
      chk({tag, ":wstb_cyc"}, wstb_cyc, 1);
      chk({tag, ":wstb_addr"}, stb_addr, addr);
      chk({tag, ":wstb_data"}, stb_data, wdata);
    end
    if (!we) exp_dout = rdata;
    chk({tag, ":data_out"}, data_out, exp_dout);
    chk({tag, ":bus_error"}, bus_error, 0);
    bus_enable = 1'b0;
    @(posedge clk); #1;
    chk({tag, ":ready_1cyc"}, ready, 0);
  endtask

  initial begin
    int cyc;
    logic seen;
    wait_of[BANK_RAM] = 0; wait_of[BANK_ROM] = 5;
    wait_of[BANK_PERIPH] = 0; wait_of[BANK_BLOCK_RAM] = 3;
    reset = 1'b1; address = '0; data_in = '0; bus_enable = 1'b0; write_enable = 1'b0;
    bank_data_in = '0; bank_ready = 4'hF; exp_dout = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk_idle_outputs("reset");

    do_access("rd_b0", 16'h0010, 16'h0000, 1'b0, 0, 16'h1234);
    do_access("wr_b3", 16'h6005, 16'hBEEF, 1'b1, 0, 16'h0000);
    do_access("wr_prot", 16'h2000, 16'h5555, 1'b1, 0, 16'h0000);
    do_access("rd_b2_stall", 16'h4000, 16'h0000, 1'b0, 10, 16'h00A5);

    // reset in the second WAIT cycle of a W=5 read abandons it
    @(negedge clk);
    address = 16'h2004; write_enable = 1'b0; bus_enable = 1'b1; bank_ready = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_abandon:in_wait", bank_enable, 4'b0010);
    reset = 1'b1; bus_enable = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_dout = '0;
    chk_idle_outputs("rst_abandon");
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (ready) seen = 1'b1;
    end
    chk("rst_abandon:no_ready", seen, 0);
    do_access("rd_after_rst", 16'h2004, 16'h0000, 1'b0, 0, 16'hC0DE);

    for (int i = 0; i < 40; i++) begin
      logic [15:0] a;
      a = 16'($urandom);
      do_access($sformatf("rnd%0d", i), a, 16'($urandom), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 7)), 16'($urandom));
    end

    // bank 2 read with bank_ready stuck low
    @(negedge clk);
    address = 16'h4002; write_enable = 1'b0; bus_enable = 1'b1;
    bank_ready = 4'hF; bank_ready[BANK_PERIPH] = 1'b0;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (ready) seen = 1'b1;
    end
`ifdef BUS_TIMEOUT_EN
    chk("timeout:seen", seen, 1);
    chk("timeout:latency", cyc, TO_CYC + 1);
    chk("timeout:bus_error", bus_error, 1);
    chk("timeout:data_out", data_out, 16'hFFFF);
    bus_enable = 1'b0;
    @(posedge clk); #1;
    chk("timeout:err_1cyc", bus_error, 0);
`else
    chk("no_timeout:no_ready", seen, 0);
    chk("no_timeout:still_sel", bank_enable, 4'b0100);
    reset = 1'b1; bus_enable = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_dout = '0;
`endif
    bank_ready = 4'hF;
    do_access("rd_final", 16'h0F00, 16'h0000, 1'b0, 2, 16'h7E57);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
